alu16: RTL and testbench
========================

ALU16 -- requirements
Module: alu16

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; the block is in reset while low.
REQ-003 The block SHALL have port A, input, 16 bits: operand A, which is the destination register value in the CPU.
REQ-004 The block SHALL have port B, input, 16 bits: operand B, which is an immediate, a data bus value or a source register.
REQ-005 The block SHALL have port aluop, input, 4 bits: operation select.
REQ-006 The block SHALL have port Y, output, 16 bits: registered result.
REQ-007 The block SHALL have port carry, output, 1 bit: registered carry-out of the last ADD; 0 for all other operations.
REQ-008 The block SHALL have port zero, output, 1 bit: registered flag, 1 when the next Y value equals 16'h0000.

Function
REQ-009 The block SHALL sample A, B and aluop on each rising clk edge and present the result on Y, carry and zero one cycle later (latency 1; no handshake; new result every cycle).
REQ-010 The block SHALL implement aluop 4'h3 (LOAD B): Y = B.
REQ-011 The block SHALL implement aluop 4'h7 (SHR): Y = A logically shifted right by B[3:0] with zero fill; shift amount 0 gives Y = A.
REQ-012 The block SHALL implement aluop 4'h8 (SHL): Y = A logically shifted left by B[3:0] with zero fill.
REQ-013 The block SHALL implement aluop 4'h9 (ADD): Y = (A + B) mod 2^16, with carry = bit 16 of the 17-bit unsigned sum.
REQ-014 The block SHALL implement aluop 4'hA (CMP): Y[15] = (A < B) unsigned, Y[14] = (A == B), Y[13:0] = 0, so the CPU takes lessThan from Y[15] and equal from Y[14].
REQ-015 The block SHALL implement aluop 4'hB (NOT): Y = bitwise complement of A; B is ignored.
REQ-016 The block SHALL implement aluop 4'hC (AND): Y = A & B.
REQ-017 The block SHALL implement aluop 4'hD (OR): Y = A | B.
REQ-018 The block SHALL implement aluop 4'hE (XOR): Y = A ^ B.
REQ-019 The block SHALL produce Y = 16'h0000 for all other aluop codes (0,1,2,4,5,6,F), and these codes SHALL NOT raise an error.
REQ-020 The block SHALL hold carry = 0 for every non-ADD operation, including CMP.
REQ-021 The block SHALL compute zero from the registered result, including CMP results; for example, CMP with A>B gives Y = 0 and zero = 1.
REQ-022 The block SHALL contain no internal state other than the output registers; consecutive results SHALL be independent.

Reset
REQ-023 The block SHALL set Y = 16'h0000, carry = 0 and zero = 1 asynchronously while reset is low.
REQ-024 The block SHALL ignore inputs while reset is low and produce its first valid result on the first rising edge after reset goes high.
REQ-025 The block SHALL discard an operation that is in flight when reset is asserted; no partial result SHALL appear on the outputs.

Structure
REQ-026 The aluop code constants (LOADB, SHR, SHL, ADD, CMP, NOT, AND, OR, XOR) SHALL be defined in a shared package that the CPU decoder also uses.
REQ-027 The block SHALL be a single module containing a combinational operation mux feeding one register stage, with no sub-module.

Verification
REQ-028 The bench SHALL cover: reset low with arbitrary inputs -> Y = 0000, carry = 0, zero = 1; after release, aluop = 9, A = FFFF, B = 0001 -> next cycle Y = 0000, carry = 1, zero = 1.
REQ-029 The bench SHALL cover: aluop = A, A = 0005, B = 0009 -> Y = 8000; A = 0009, B = 0009 -> Y = 4000; A = 0009, B = 0005 -> Y = 0000, zero = 1.
REQ-030 The bench SHALL cover: aluop = 7, A = 8001, B = 0004 -> Y = 0800; aluop = 8, A = 8001, B = 0001 -> Y = 0002; B = 0000 -> Y = A.
REQ-031 The bench SHALL cover: A = F0F0, B = FF00 -> AND gives F000, OR gives FFF0, XOR gives 0FF0, NOT gives 0F0F, and aluop = 3 gives FF00.
REQ-032 The bench SHALL cover: aluop = 0 / F with any operands -> Y = 0000, zero = 1, carry = 0.
REQ-033 The bench SHALL cover back-to-back ops each cycle -> each result appears exactly one cycle after its inputs; reset asserted mid-stream -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared ALU definitions: operation codes decoded by both the CPU and alu16.
package alu16_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] LOADB = 4'h3;
  localparam logic [3:0] SHR   = 4'h7;
  localparam logic [3:0] SHL   = 4'h8;
  localparam logic [3:0] ADD   = 4'h9;
  localparam logic [3:0] CMP   = 4'hA;
  localparam logic [3:0] NOT   = 4'hB;
  localparam logic [3:0] AND   = 4'hC;
  localparam logic [3:0] OR    = 4'hD;
  localparam logic [3:0] XOR   = 4'hE;

endpackage

// File: rtl/alu16.sv
// 16-bit ALU: combinational operation mux feeding a single output register stage.
module alu16
  import alu16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        aluop,
  output logic [DATA_W-1:0] Y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W-1:0] y_p0;
  logic              carry_p0;
  logic [DATA_W:0]   sum_p0;

  assign sum_p0 = {1'b0, A} + {1'b0, B};

  always_comb begin
    y_p0     = '0;
    carry_p0 = 1'b0;
    case (aluop)
      LOADB: y_p0 = B;
      SHR:   y_p0 = A >> B[3:0];
      SHL:   y_p0 = A << B[3:0];
      ADD: begin
        y_p0     = sum_p0[DATA_W-1:0];
        carry_p0 = sum_p0[DATA_W];
      end
      // lessThan in the MSB, equal just below it, remaining bits clear
      CMP:   y_p0 = {(A < B), (A == B), {(DATA_W-2){1'b0}}};
      NOT:   y_p0 = ~A;
      AND:   y_p0 = A & B;
      OR:    y_p0 = A | B;
      XOR:   y_p0 = A ^ B;
      default: y_p0 = '0;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Y     <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else begin
      Y     <= y_p0;
      carry <= carry_p0;
      zero  <= (y_p0 == '0);
    end
  end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed corner cases plus randomized ops against a reference model.
module tb_alu16;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  aluop;
  logic [15:0] Y;
  logic        carry;
  logic        zero;

  int n_cmp;
  int n_bad;

  alu16 dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .aluop (aluop),
    .Y     (Y),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour from the operation table, using plain integer arithmetic.
  function automatic void ref_model(input int a, input int b, input int op,
                                    output int y, output int c);
    int sh;
    sh = b % 16;
    c  = 0;
    case (op)
      3:  y = b;
      7:  y = a / (1 << sh);
      8:  y = (a * (1 << sh)) % 65536;
      9: begin
        y = (a + b) % 65536;
        c = ((a + b) >= 65536) ? 1 : 0;
      end
      10: y = ((a < b) ? 32768 : 0) + ((a == b) ? 16384 : 0);
      11: y = 65535 - a;
      12: y = a & b;
      13: y = a | b;
      14: y = a ^ b;
      default: y = 0;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    int ey, ec;
    @(negedge clk);
    A = a; B = b; aluop = op;
    @(posedge clk);
    #1;
    ref_model(int'(a), int'(b), int'(op), ey, ec);
    chk_result({tag, "_Y"}, 32'(Y), 32'(ey));
    chk_result({tag, "_carry"}, 32'(carry), 32'(ec));
    chk_result({tag, "_zero"}, 32'(zero), (ey == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk_result({tag, "_Y"}, 32'(Y), 32'h0);
    chk_result({tag, "_carry"}, 32'(carry), 32'h0);
    chk_result({tag, "_zero"}, 32'(zero), 32'h1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    A = 16'hFFFF; B = 16'h0001; aluop = 4'h9;

    // Reset low with arbitrary inputs toggling across edges
    repeat (3) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); aluop = 4'($urandom);
    end
    @(posedge clk); #1;
    check_reset_state("rst_hold");

    @(negedge clk);
    reset = 1'b1;
    do_op("add_wrap", 16'hFFFF, 16'h0001, 4'h9);
    chk_result("add_wrap_direct_carry", 32'(carry), 32'h1);

    do_op("cmp_lt", 16'h0005, 16'h0009, 4'hA);
    chk_result("cmp_lt_direct", 32'(Y), 32'h8000);
    do_op("cmp_eq", 16'h0009, 16'h0009, 4'hA);
    chk_result("cmp_eq_direct", 32'(Y), 32'h4000);
    do_op("cmp_gt", 16'h0009, 16'h0005, 4'hA);
    chk_result("cmp_gt_direct_zero", 32'(zero), 32'h1);

    do_op("shr4", 16'h8001, 16'h0004, 4'h7);
    chk_result("shr4_direct", 32'(Y), 32'h0800);
    do_op("shl1", 16'h8001, 16'h0001, 4'h8);
    chk_result("shl1_direct", 32'(Y), 32'h0002);
    do_op("shl0", 16'h8001, 16'h0000, 4'h8);
    chk_result("shl0_direct", 32'(Y), 32'h8001);
    do_op("shr0", 16'h8001, 16'h0000, 4'h7);
    chk_result("shr0_direct", 32'(Y), 32'h8001);

    do_op("and", 16'hF0F0, 16'hFF00, 4'hC);
    chk_result("and_direct", 32'(Y), 32'hF000);
    do_op("or", 16'hF0F0, 16'hFF00, 4'hD);
    chk_result("or_direct", 32'(Y), 32'hFFF0);
    do_op("xor", 16'hF0F0, 16'hFF00, 4'hE);
    chk_result("xor_direct", 32'(Y), 32'h0FF0);
    do_op("not", 16'hF0F0, 16'hFF00, 4'hB);
    chk_result("not_direct", 32'(Y), 32'h0F0F);
    do_op("loadb", 16'hF0F0, 16'hFF00, 4'h3);
    chk_result("loadb_direct", 32'(Y), 32'hFF00);

    do_op("add_carry_then_op0", 16'hFFFF, 16'h0003, 4'h9);
    do_op("op0", 16'h1234, 16'h5678, 4'h0);
    do_op("add_carry_then_opF", 16'hFFFF, 16'h0003, 4'h9);
    do_op("opF", 16'hABCD, 16'hFFFF, 4'hF);
    do_op("op5", 16'hABCD, 16'h0001, 4'h5);

    // Back-to-back randomized operations, one per cycle
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = (i % 4 == 0) ? 4'($urandom) : 4'($urandom_range(7, 14));
      do_op("rand", 16'($urandom), 16'($urandom), op);
    end

    // Reset asserted mid-cycle must clear outputs without a clock edge
    do_op("pre_rst", 16'hFFFF, 16'h0003, 4'h9);
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; aluop = 4'h9;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst_async");
    @(posedge clk); #1;
    check_reset_state("rst_inflight");
    @(negedge clk);
    reset = 1'b1;
    do_op("post_rst", 16'h1111, 16'h2222, 4'h9);
    chk_result("post_rst_direct", 32'(Y), 32'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
